// File: rtl/conv_window_fetch.sv
// Read-side walker for the padded input pre-buffer: fetches 3x3 stride-1 windows
// channel by channel and hands them to the PE array, flipping the buffer select per pass.
module conv_window_fetch #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [15:0]           i_fm_row,
   input  logic [15:0]           i_fm_col,
   input  logic [15:0]           i_fm_n,
   output logic [ADDR_W-1:0]     o_conv_addr,
   input  logic [DATA_W-1:0]     i_conv_din,
   output logic [9*DATA_W-1:0]   o_win_data,
   output logic                  o_win_vld,
   input  logic                  i_win_rdy,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_buf_sel,
   output logic [2:0]            o_fsm_state
);

   // Handshake: a window transfers on any cycle with o_win_vld & i_win_rdy; o_win_vld
   // never drops and o_win_data never changes until that transfer has happened.
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] FETCH = 3'd1;
   localparam logic [2:0] DRAIN = 3'd2;
   localparam logic [2:0] HOLD  = 3'd3;
   localparam logic [2:0] FIN   = 3'd4;

   logic [2:0]          state_q, state_d;
   logic [15:0]         row_q, row_d, col_q, col_d, n_q, n_d;
   logic [15:0]         x_q, x_d, y_q, y_d, c_q, c_d;
   logic [ADDR_W-1:0]   w_q, w_d, addr_q, addr_d, tl_q, tl_d, tl_nx;
   logic [3:0]          k_q, k_d, slot;
   logic [9*DATA_W-1:0] win_q, win_d;
   logic                sel_q, sel_d;
   logic                last_col, last_row, last_chan;

   assign last_col  = (x_q == col_q - 16'd1);
   assign last_row  = (y_q == row_q - 16'd1);
   assign last_chan = (c_q == n_q - 16'd1);
   // Data returning this cycle belongs to the address issued last cycle.
   assign slot      = k_q - 4'd1;

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      n_d     = n_q;
      x_d     = x_q;
      y_d     = y_q;
      c_d     = c_q;
      w_d     = w_q;
      addr_d  = addr_q;
      tl_d    = tl_q;
      tl_nx   = tl_q;
      k_d     = k_q;
      win_d   = win_q;
      sel_d   = sel_q;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               row_d = i_fm_row;
               col_d = i_fm_col;
               n_d   = i_fm_n;
               w_d   = ADDR_W'(i_fm_col) + ADDR_W'(2);
               x_d   = '0;
               y_d   = '0;
               c_d   = '0;
               k_d   = '0;
               if (i_fm_row == 16'd0 || i_fm_col == 16'd0 || i_fm_n == 16'd0) begin
                  state_d = FIN;
               end else begin
                  addr_d  = '0;
                  tl_d    = '0;
                  state_d = FETCH;
               end
            end
         end
         FETCH: begin
            if (k_q != 4'd0) win_d[DATA_W*slot +: DATA_W] = i_conv_din;
            if (k_q == 4'd8) begin
               k_d     = '0;
               state_d = DRAIN;
            end else begin
               k_d    = k_q + 4'd1;
               addr_d = addr_q + ((k_q == 4'd2 || k_q == 4'd5) ? w_q - ADDR_W'(2) : ADDR_W'(1));
            end
         end
         DRAIN: begin
            win_d[DATA_W*8 +: DATA_W] = i_conv_din;
            state_d = HOLD;
         end
         HOLD: begin
            if (i_win_rdy) begin
               if (last_col && last_row && last_chan) begin
                  state_d = FIN;
               end else begin
                  state_d = FETCH;
                  if (!last_col) begin
                     x_d   = x_q + 16'd1;
                     tl_nx = tl_q + ADDR_W'(1);
                  end else if (!last_row) begin
                     x_d   = '0;
                     y_d   = y_q + 16'd1;
                     tl_nx = tl_q + ADDR_W'(3);
                  end else begin
                     // Skipping two padding rows lands exactly on the next channel plane.
                     x_d   = '0;
                     y_d   = '0;
                     c_d   = c_q + 16'd1;
                     tl_nx = tl_q + (w_q << 1) + ADDR_W'(3);
                  end
                  tl_d   = tl_nx;
                  addr_d = tl_nx;
               end
            end
         end
         FIN: begin
            sel_d   = ~sel_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
         n_q     <= '0;
         x_q     <= '0;
         y_q     <= '0;
         c_q     <= '0;
         w_q     <= '0;
         addr_q  <= '0;
         tl_q    <= '0;
         k_q     <= '0;
         win_q   <= '0;
         sel_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         n_q     <= n_d;
         x_q     <= x_d;
         y_q     <= y_d;
         c_q     <= c_d;
         w_q     <= w_d;
         addr_q  <= addr_d;
         tl_q    <= tl_d;
         k_q     <= k_d;
         win_q   <= win_d;
         sel_q   <= sel_d;
      end
   end

   assign o_conv_addr = addr_q;
   assign o_win_data  = win_q;
   assign o_win_vld   = (state_q == HOLD);
   assign o_busy      = (state_q != IDLE);
   assign o_done      = (state_q == FIN);
   assign o_buf_sel   = sel_q;
   assign o_fsm_state = state_q;

endmodule

// File: tb/tb_conv_window_fetch.sv
// Bench for conv_window_fetch: a buffer model feeds read data, and a cycle-level
// reference built from window geometry and handshake timing is compared every cycle.
module tb_conv_window_fetch;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;
   localparam int WIN_W  = 9 * DATA_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [15:0]       fm_row = '0, fm_col = '0, fm_n = '0;
   logic [ADDR_W-1:0] conv_addr;
   logic [DATA_W-1:0] conv_din = '0;
   logic [WIN_W-1:0]  win_data;
   logic              win_vld, win_rdy = 1'b0, busy, done, buf_sel;
   logic [2:0]        fsm_state;

   always #5 clk = ~clk;

   conv_window_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start),
      .i_fm_row(fm_row), .i_fm_col(fm_col), .i_fm_n(fm_n),
      .o_conv_addr(conv_addr), .i_conv_din(conv_din),
      .o_win_data(win_data), .o_win_vld(win_vld), .i_win_rdy(win_rdy),
      .o_busy(busy), .o_done(done), .o_buf_sel(buf_sel), .o_fsm_state(fsm_state)
   );

   int total = 0;
   int bad = 0;

   task automatic check(input string name, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // Buffer contents: an affine function of the address, reseeded per pass.
   int unsigned mem_mul = 1;
   int unsigned mem_add = 0;
   function automatic logic [DATA_W-1:0] mem_val(input logic [ADDR_W-1:0] a);
      return DATA_W'(int'(a) * mem_mul + mem_add);
   endfunction

   // 1-cycle read latency: data for last cycle's address is presented this cycle.
   logic [ADDR_W-1:0] addr_seen = '0;
   always @(negedge clk) begin
      conv_din  = mem_val(addr_seen);
      addr_seen = conv_addr;
   end

   // Reference model state.
   logic [ADDR_W-1:0] exp_addr_q[$];
   logic [WIN_W-1:0]  exp_q[$];
   logic [ADDR_W-1:0] pass_addr[$];
   logic [WIN_W-1:0]  pass_win[$];
   bit m_busy, m_vld, m_done, m_sel, m_fresh, armed;
   int fetch_left, vld_wait;
   int cyc_ctr = 0, start_cyc = 0, first_vld_lat = -1, done_lat = -1;
   int xfer_cnt = 0, done_cnt = 0;

   task automatic gen_pass(input int r, input int c, input int n);
      int w, p, a;
      logic [WIN_W-1:0] win;
      w = c + 2;
      p = w * (r + 2);
      for (int ch = 0; ch < n; ch++)
         for (int y = 0; y < r; y++)
            for (int x = 0; x < c; x++) begin
               win = '0;
               for (int k = 0; k < 9; k++) begin
                  a = ch * p + (y + k / 3) * w + x + k % 3;
                  exp_addr_q.push_back(ADDR_W'(a));
                  pass_addr.push_back(ADDR_W'(a));
                  win[k*DATA_W +: DATA_W] = mem_val(ADDR_W'(a));
               end
               exp_q.push_back(win);
               pass_win.push_back(win);
            end
   endtask

   task automatic model_reset();
      exp_addr_q.delete();
      exp_q.delete();
      m_busy = 0; m_vld = 0; m_done = 0; m_sel = 0; m_fresh = 1;
      fetch_left = 0; vld_wait = 0;
   endtask

   always @(negedge clk) begin
      bit cur_vld, cur_busy, was_done;
      cyc_ctr++;
      if (!armed) begin
         if (rst) begin
            model_reset();
            armed = 1;
         end
      end else begin
         check("busy", WIN_W'(busy), WIN_W'(m_busy));
         check("win_vld", WIN_W'(win_vld), WIN_W'(m_vld));
         check("done", WIN_W'(done), WIN_W'(m_done));
         check("buf_sel", WIN_W'(buf_sel), WIN_W'(m_sel));
         if (m_fresh) begin
            check("idle_addr", WIN_W'(conv_addr), '0);
            check("idle_data", win_data, '0);
         end
         if (fetch_left > 0) begin
            if (exp_addr_q.size() == 0) check("addr_underflow", 1, 0);
            else check("conv_addr", WIN_W'(conv_addr), WIN_W'(exp_addr_q.pop_front()));
         end
         if (m_vld && exp_q.size() > 0) check("win_data", win_data, exp_q[0]);
         if (win_vld && first_vld_lat < 0) first_vld_lat = cyc_ctr - start_cyc;
         if (done) begin
            done_cnt++;
            if (done_lat < 0) done_lat = cyc_ctr - start_cyc;
         end
         if (rst) begin
            model_reset();
         end else begin
            cur_vld  = m_vld;
            cur_busy = m_busy;
            was_done = m_done;
            m_done = 0;
            if (was_done) begin
               m_busy = 0;
               m_sel  = ~m_sel;
            end
            if (vld_wait > 0) begin
               vld_wait--;
               if (vld_wait == 0) m_vld = 1;
            end
            if (fetch_left > 0) begin
               fetch_left--;
               if (fetch_left == 0) vld_wait = 1;
            end
            if (cur_vld && win_rdy) begin
               if (exp_q.size() > 0) void'(exp_q.pop_front());
               xfer_cnt++;
               m_vld = 0;
               if (exp_q.size() == 0) m_done = 1;
               else fetch_left = 9;
            end
            if (start && !cur_busy) begin
               m_busy = 1;
               m_fresh = 0;
               start_cyc = cyc_ctr;
               first_vld_lat = -1;
               done_lat = -1;
               pass_addr.delete();
               pass_win.delete();
               if (fm_row == 0 || fm_col == 0 || fm_n == 0) m_done = 1;
               else begin
                  gen_pass(int'(fm_row), int'(fm_col), int'(fm_n));
                  fetch_left = 9;
               end
            end
         end
      end
   end

   // Consumer: 0 = always ready, 1 = random, 2 = hold each window 20 cycles.
   int rdy_mode = 0;
   int vld_run = 0;
   always @(posedge clk) begin
      #1;
      if (win_vld) vld_run++;
      else vld_run = 0;
      case (rdy_mode)
         0: win_rdy = 1'b1;
         1: win_rdy = 1'($urandom_range(0, 1));
         default: win_rdy = (vld_run > 20);
      endcase
   end

   int xfer0, done0;

   task automatic run_pass(input int r, input int c, input int n, input int mode,
                           input int unsigned mul, input int unsigned add, input bit busy_poke);
      bit timeout;
      mem_mul = mul;
      mem_add = add;
      rdy_mode = mode;
      xfer0 = xfer_cnt;
      done0 = done_cnt;
      fm_row = 16'(r); fm_col = 16'(c); fm_n = 16'(n);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      fm_row = 16'($urandom_range(1, 9));
      fm_col = 16'($urandom_range(1, 9));
      fm_n   = 16'($urandom_range(1, 9));
      timeout = 1;
      for (int i = 0; i < 20000; i++) begin
         if (!m_busy) begin
            timeout = 0;
            break;
         end
         start = busy_poke && (i == 30);
         @(posedge clk); #1;
      end
      start = 1'b0;
      check("pass_finish_timeout", WIN_W'(timeout), '0);
   endtask

   int pin_first[9]  = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
   int pin_last[9]   = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
   int pin_chan1[9]  = '{16, 17, 18, 20, 21, 22, 24, 25, 26};
   logic [WIN_W-1:0] pin_last_win = 72'h0f0e0d0b0a09070605;

   initial begin
      bit reached;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_busy", WIN_W'(busy), '0);
      check("rst_vld", WIN_W'(win_vld), '0);
      check("rst_addr", WIN_W'(conv_addr), '0);
      check("rst_data", win_data, '0);
      check("rst_sel", WIN_W'(buf_sel), '0);
      @(posedge clk); #1;

      // 2x2x1 with buffer[a] = a
      run_pass(2, 2, 1, 0, 1, 0, 0);
      check("t1_windows", WIN_W'(pass_addr.size()), WIN_W'(36));
      for (int k = 0; k < 9; k++) begin
         check("t1_pin_first_addr", WIN_W'(pass_addr[k]), WIN_W'(pin_first[k]));
         check("t1_pin_last_addr", WIN_W'(pass_addr[27 + k]), WIN_W'(pin_last[k]));
      end
      check("t1_pin_last_win", pass_win[3], pin_last_win);
      check("t1_xfers", WIN_W'(xfer_cnt - xfer0), WIN_W'(4));
      check("t1_dones", WIN_W'(done_cnt - done0), WIN_W'(1));
      check("t1_sel", WIN_W'(buf_sel), WIN_W'(1));

      // 2x2x2, random backpressure, ignored start while busy
      run_pass(2, 2, 2, 1, 5, 3, 1);
      for (int k = 0; k < 9; k++)
         check("t2_pin_chan1_addr", WIN_W'(pass_addr[36 + k]), WIN_W'(pin_chan1[k]));
      check("t2_xfers", WIN_W'(xfer_cnt - xfer0), WIN_W'(8));
      check("t2_dones", WIN_W'(done_cnt - done0), WIN_W'(1));
      check("t2_sel", WIN_W'(buf_sel), WIN_W'(0));

      // 3x3x1 with 20-cycle holds
      run_pass(3, 3, 1, 2, 7, 11, 0);
      check("t3_first_vld_cycle", WIN_W'(first_vld_lat), WIN_W'(11));
      check("t3_xfers", WIN_W'(xfer_cnt - xfer0), WIN_W'(9));
      check("t3_sel", WIN_W'(buf_sel), WIN_W'(1));

      // Reset in FETCH of window 2
      mem_mul = 3; mem_add = 7; rdy_mode = 0;
      xfer0 = xfer_cnt;
      fm_row = 16'd2; fm_col = 16'd2; fm_n = 16'd1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      reached = 0;
      for (int i = 0; i < 200; i++) begin
         if (xfer_cnt > xfer0) begin
            reached = 1;
            break;
         end
         @(posedge clk); #1;
      end
      check("rst_reach_window2", WIN_W'(reached), WIN_W'(1));
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_busy", WIN_W'(busy), '0);
      check("midrst_vld", WIN_W'(win_vld), '0);
      check("midrst_done", WIN_W'(done), '0);
      check("midrst_addr", WIN_W'(conv_addr), '0);
      check("midrst_data", win_data, '0);
      check("midrst_sel", WIN_W'(buf_sel), '0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Back-to-back passes: select 0 -> 1 -> 0
      run_pass(2, 2, 1, 0, 9, 1, 0);
      check("b2b_sel_a", WIN_W'(buf_sel), WIN_W'(1));
      run_pass(2, 3, 1, 0, 13, 5, 0);
      check("b2b_sel_b", WIN_W'(buf_sel), WIN_W'(0));

      // Zero column count
      run_pass(3, 0, 2, 0, 1, 0, 0);
      check("zero_done_cycle", WIN_W'(done_lat), WIN_W'(1));
      check("zero_no_vld", WIN_W'(first_vld_lat), WIN_W'(-1));
      check("zero_xfers", WIN_W'(xfer_cnt - xfer0), '0);
      check("zero_sel", WIN_W'(buf_sel), WIN_W'(1));

      // Random geometries and backpressure
      for (int t = 0; t < 4; t++) begin
         int r, c, n;
         r = $urandom_range(1, 4);
         c = $urandom_range(1, 4);
         n = $urandom_range(1, 2);
         run_pass(r, c, n, $urandom_range(0, 1), ($urandom_range(0, 60) * 2) + 1,
                  $urandom_range(0, 255), 0);
         check("rand_xfers", WIN_W'(xfer_cnt - xfer0), WIN_W'(r * c * n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      bad++;
      $display("FAIL watchdog actual=running required=finished");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
